dmadd_sequencer: RTL and testbench

- Job-level controller for one DMADD delta/multiply-add engine.
- Accepts a job (MIN, MAX or MADD plus a load-entry count) over a valid/ready handshake.
- Sequences the engine through clear, init, load, run and settle phases, then captures the engine's 12-bit output and returns it on a valid/ready result port.
- Sits between the host command interface and the engine; it owns the engine's reset, load, run and insn pins exclusively.

---
 rtl/dmadd_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dmadd_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmadd_sequencer.sv
// Job-level sequencer for a DMADD engine: clear, init, load, run, settle, then hand back
// the engine's 12-bit output over a valid/ready result port.
module dmadd_sequencer #(
    parameter int unsigned RUN_CYCLES    = 16,
    parameter int unsigned CLR_CYCLES    = 1,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [1:0]  job_op,
    input  logic [4:0]  job_len,
    input  logic        ent_valid,
    output logic        ent_ready,
    input  logic [3:0]  ent_index,
    input  logic [3:0]  ent_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic        eng_rst_n,
    output logic        eng_run,
    output logic        eng_load,
    output logic [1:0]  eng_insn,
    output logic [3:0]  eng_index,
    output logic [3:0]  eng_data,
    input  logic [11:0] eng_out
);

    localparam logic [1:0] OpMin  = 2'b00;
    localparam logic [1:0] OpMax  = 2'b01;
    localparam logic [1:0] OpMadd = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StInit,
        StLoad,
        StRun,
        StSettle,
        StResult
    } state_e;

    state_e      state;
    logic [1:0]  op;
    logic [4:0]  len_cnt;
    logic [7:0]  run_cnt;
    logic [3:0]  clr_cnt;
    logic [3:0]  settle_cnt;
    logic [1:0]  nop_insn;
    logic        ent_fire;

    assign job_ready = !rst && (state == StIdle);
    assign ent_ready = !rst && (state == StLoad) && (len_cnt != 5'd0);
    assign ent_fire  = ent_ready && ent_valid;
    assign res_valid = !rst && (state == StResult);
    assign busy      = !rst && (state != StIdle);
    assign eng_rst_n = !rst && (state != StClear);

    // MADD uses 11 as its idle opcode; an illegal op leaves the engine at 00.
    always_comb begin
        nop_insn = 2'b00;
        case (op)
            OpMin, OpMax: nop_insn = op;
            OpMadd:       nop_insn = 2'b11;
            default:      nop_insn = 2'b00;
        endcase
    end

    always_comb begin
        eng_run   = 1'b0;
        eng_load  = 1'b0;
        eng_insn  = 2'b00;
        eng_index = 4'd0;
        eng_data  = 4'd0;
        if (!rst) begin
            case (state)
                StIdle: ;
                StInit: eng_insn = (op == OpMadd) ? 2'b01 : op;
                StLoad: begin
                    if (ent_fire) begin
                        eng_load  = 1'b1;
                        eng_insn  = op;
                        eng_index = ent_index;
                        eng_data  = ent_data;
                    end else begin
                        eng_insn = nop_insn;
                    end
                end
                StRun: begin
                    eng_run  = 1'b1;
                    eng_insn = op;
                end
                default: eng_insn = nop_insn;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            op         <= 2'b00;
            len_cnt    <= 5'd0;
            run_cnt    <= 8'd0;
            clr_cnt    <= 4'd0;
            settle_cnt <= 4'd0;
            res_data   <= 12'd0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (job_valid) begin
                        op      <= job_op;
                        len_cnt <= job_len;
                        if (job_op == 2'b11 || job_len > 5'd16) begin
                            state    <= StResult;
                            res_data <= 12'hFFF;
                            res_err  <= 1'b1;
                        end else begin
                            state   <= StClear;
                            clr_cnt <= 4'(CLR_CYCLES - 1);
                        end
                    end
                end
                StClear: begin
                    if (clr_cnt == 4'd0) state <= StInit;
                    else clr_cnt <= clr_cnt - 4'd1;
                end
                StInit: begin
                    if (len_cnt == 5'd0) begin
                        state   <= StRun;
                        run_cnt <= 8'(RUN_CYCLES - 1);
                    end else begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    if (ent_fire) begin
                        len_cnt <= len_cnt - 5'd1;
                        if (len_cnt == 5'd1) begin
                            state   <= StRun;
                            run_cnt <= 8'(RUN_CYCLES - 1);
                        end
                    end
                end
                StRun: begin
                    if (run_cnt == 8'd0) begin
                        if (SETTLE_CYCLES == 0) begin
                            state    <= StResult;
                            res_data <= eng_out;
                            res_err  <= 1'b0;
                        end else begin
                            state      <= StSettle;
                            settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        end
                    end else begin
                        run_cnt <= run_cnt - 8'd1;
                    end
                end
                StSettle: begin
                    if (settle_cnt == 4'd0) begin
                        state    <= StResult;
                        res_data <= eng_out;
                        res_err  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                StResult: begin
                    if (res_ready) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Directed bench for dmadd_sequencer; cycle 0 of each job is its handshake cycle.
module tb_dmadd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [1:0]  job_op;
    logic [4:0]  job_len;
    logic        ent_valid;
    logic        ent_ready;
    logic [3:0]  ent_index;
    logic [3:0]  ent_data;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic        res_err;
    logic        busy;
    logic        eng_rst_n;
    logic        eng_run;
    logic        eng_load;
    logic [1:0]  eng_insn;
    logic [3:0]  eng_index;
    logic [3:0]  eng_data;
    logic [11:0] eng_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmadd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_op    (job_op),
        .job_len   (job_len),
        .ent_valid (ent_valid),
        .ent_ready (ent_ready),
        .ent_index (ent_index),
        .ent_data  (ent_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy),
        .eng_rst_n (eng_rst_n),
        .eng_run   (eng_run),
        .eng_load  (eng_load),
        .eng_insn  (eng_insn),
        .eng_index (eng_index),
        .eng_data  (eng_data),
        .eng_out   (eng_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        job_valid = 1'b0;
        job_op    = 2'b00;
        job_len   = 5'd0;
        ent_valid = 1'b0;
        ent_index = 4'd0;
        ent_data  = 4'd0;
        res_ready = 1'b0;
        eng_out   = 12'd0;
    endtask

    // MIN, len 2, entries (5,0),(9,0); a stray entry in CLEAR must be ignored.
    task automatic min_len2(input string name);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            clear_inputs();
            job_valid = (c == 0);
            job_len   = 5'd2;
            ent_valid = (c == 1 || c == 3 || c == 4);
            ent_index = (c == 4) ? 4'd9 : 4'd5;
            eng_out   = (c >= 21) ? 12'h005 : 12'h000;
            res_ready = (c == 22);
            #2;
            check($sformatf("%s c%0d rst_n", name, c), 32'(eng_rst_n), 32'(c != 1));
            check($sformatf("%s c%0d ent_ready", name, c), 32'(ent_ready), 32'(c == 3 || c == 4));
            check($sformatf("%s c%0d load", name, c), 32'(eng_load), 32'(c == 3 || c == 4));
            check($sformatf("%s c%0d run", name, c), 32'(eng_run), 32'(c >= 5 && c <= 20));
            check($sformatf("%s c%0d res_valid", name, c), 32'(res_valid), 32'(c == 22));
            check($sformatf("%s c%0d job_ready", name, c), 32'(job_ready), 32'(c == 0 || c == 23));
            check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c >= 1 && c <= 22));
            if (c == 2) check($sformatf("%s init insn", name), 32'(eng_insn), 32'h0);
            if (c == 3) check($sformatf("%s idx0", name), 32'(eng_index), 32'h5);
            if (c == 4) check($sformatf("%s idx1", name), 32'(eng_index), 32'h9);
            if (c == 22) begin
                check($sformatf("%s res_data", name), 32'(res_data), 32'h005);
                check($sformatf("%s res_err", name), 32'(res_err), 32'h0);
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst eng_rst_n", 32'(eng_rst_n), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst res_valid", 32'(res_valid), 32'h0);
        check("rst res_data", 32'(res_data), 32'h0);
        check("rst eng_run", 32'(eng_run), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("idle job_ready", 32'(job_ready), 32'h1);
        check("idle eng_rst_n", 32'(eng_rst_n), 32'h1);
        check("idle insn", 32'(eng_insn), 32'h0);
        check("idle res_err", 32'(res_err), 32'h0);

        min_len2("min");

        // MADD, len 1, entry (4,3)
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            clear_inputs();
            job_valid = (c == 0);
            job_op    = 2'b10;
            job_len   = 5'd1;
            ent_valid = (c == 3);
            ent_index = 4'd4;
            ent_data  = 4'd3;
            eng_out   = 12'h2A5;
            res_ready = (c == 21);
            #2;
            if (c == 2) check("madd init insn", 32'(eng_insn), 32'h1);
            if (c == 3) begin
                check("madd load", 32'(eng_load), 32'h1);
                check("madd load insn", 32'(eng_insn), 32'h2);
                check("madd idx", 32'(eng_index), 32'h4);
                check("madd data", 32'(eng_data), 32'h3);
            end
            if (c >= 4 && c <= 19) check($sformatf("madd c%0d run insn", c), 32'(eng_insn), 32'h2);
            if (c == 20 || c == 21) check($sformatf("madd c%0d nop insn", c), 32'(eng_insn), 32'h3);
            if (c == 21) check("madd res_data", 32'(res_data), 32'h2A5);
            check($sformatf("madd c%0d res_valid", c), 32'(res_valid), 32'(c == 21));
        end

        // MAX, len 3, two stall cycles before entry 3
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            clear_inputs();
            job_valid = (c == 0);
            job_op    = 2'b01;
            job_len   = 5'd3;
            ent_valid = (c == 3 || c == 4 || c == 7);
            ent_index = (c == 3) ? 4'd1 : (c == 4) ? 4'd2 : 4'd3;
            eng_out   = 12'h123;
            res_ready = (c == 25);
            #2;
            check($sformatf("stall c%0d load", c), 32'(eng_load), 32'(c == 3 || c == 4 || c == 7));
            check($sformatf("stall c%0d run", c), 32'(eng_run), 32'(c >= 8 && c <= 23));
            check($sformatf("stall c%0d ent_ready", c), 32'(ent_ready), 32'(c >= 3 && c <= 7));
            if (c == 2 || c == 5 || c == 6 || (c >= 8 && c <= 23))
                check($sformatf("stall c%0d insn", c), 32'(eng_insn), 32'h1);
            check($sformatf("stall c%0d res_valid", c), 32'(res_valid), 32'(c == 25));
            if (c == 25) check("stall res_data", 32'(res_data), 32'h123);
            check($sformatf("stall c%0d job_ready", c), 32'(job_ready), 32'(c == 0 || c == 26));
        end

        // Illegal jobs: op 11, then len 20
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                clear_inputs();
                job_valid = (c == 0);
                job_op    = (j == 0) ? 2'b11 : 2'b00;
                job_len   = (j == 0) ? 5'd1 : 5'd20;
                res_ready = (c == 1);
                #2;
                check($sformatf("ill%0d c%0d rst_n", j, c), 32'(eng_rst_n), 32'h1);
                check($sformatf("ill%0d c%0d run", j, c), 32'(eng_run), 32'h0);
                check($sformatf("ill%0d c%0d load", j, c), 32'(eng_load), 32'h0);
                check($sformatf("ill%0d c%0d insn", j, c), 32'(eng_insn), 32'h0);
                check($sformatf("ill%0d c%0d res_valid", j, c), 32'(res_valid), 32'(c == 1));
                check($sformatf("ill%0d c%0d job_ready", j, c), 32'(job_ready), 32'(c != 1));
                if (c == 1) begin
                    check($sformatf("ill%0d res_data", j), 32'(res_data), 32'hFFF);
                    check($sformatf("ill%0d res_err", j), 32'(res_err), 32'h1);
                end
            end
        end

        // Backpressure: MIN len 0, result at c20, res_ready held off until c30
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            clear_inputs();
            job_valid = (c == 0);
            eng_out   = (c <= 19) ? 12'h0AB : 12'(12'h700 + c);
            res_ready = (c == 30);
            #2;
            if (c >= 20 && c <= 30) begin
                check($sformatf("bp c%0d res_valid", c), 32'(res_valid), 32'h1);
                check($sformatf("bp c%0d res_data", c), 32'(res_data), 32'h0AB);
                check($sformatf("bp c%0d res_err", c), 32'(res_err), 32'h0);
            end
            check($sformatf("bp c%0d job_ready", c), 32'(job_ready), 32'(c == 0 || c == 31));
        end

        // Reset in the middle of RUN (MIN len 0 runs c3..c18)
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            clear_inputs();
            job_valid = (c == 0);
            rst       = (c >= 8);
            #2;
            if (c == 5) check("mid run active", 32'(eng_run), 32'h1);
            if (c == 9) begin
                check("mid eng_run", 32'(eng_run), 32'h0);
                check("mid eng_rst_n", 32'(eng_rst_n), 32'h0);
                check("mid busy", 32'(busy), 32'h0);
                check("mid res_valid", 32'(res_valid), 32'h0);
                check("mid res_data", 32'(res_data), 32'h0);
            end
        end
        rst = 1'b0;
        min_len2("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
